dmem_responder: RTL and testbench

- Multi-cycle data-memory responder: the slave end of the memory-stage request interface.
- Accepts one read or write request at a time from the memory stage and holds the pipeline with Stall while busy.
- Completes each request after a fixed, parameterised latency with a one-cycle Done pulse.
- Replaces the single-cycle data memory, so the pipeline sees realistic latency and alignment faults.

---
 rtl/dmem_responder_if.sv | 25 ++
 rtl/dmem_responder.sv | 113 +++++++++++
 tb/tb_dmem_responder.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Memory-stage request interface between the pipeline (master) and the
// data-memory responder (slave).
interface dmem_responder_if #(
  parameter int ADDR_W = 16
);
  logic              Req;
  logic              Wr;
  logic [ADDR_W-1:0] Addr;
  logic [15:0]       DataIn;
  logic              Halt;
  logic              Stall;
  logic              Done;
  logic [15:0]       DataOut;
  logic              Err;

  modport master (
    output Req, Wr, Addr, DataIn, Halt,
    input  Stall, Done, DataOut, Err
  );

  modport slave (
    input  Req, Wr, Addr, DataIn, Halt,
    output Stall, Done, DataOut, Err
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one read/write at a time,
// stalls the initiator while busy and completes after LAT cycles with a
// one-cycle Done pulse. Unaligned accesses complete with Err and no array access.
module dmem_responder #(
  parameter int ADDR_W = 16,
  parameter int LAT    = 4
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] CNT_INIT = (LAT > 1) ? 4'(LAT - 2) : 4'd0;

  state_t            state, nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              cap_wr;
  logic [ADDR_W-1:0] cap_addr;
  logic [15:0]       cap_data;
  logic [15:0]       dout;
  logic              err;
  logic              accept;
  logic              enter_done;
  logic              eff_wr;
  logic [ADDR_W-1:0] eff_addr;
  logic [15:0]       eff_data;

  logic [15:0] mem [0:(1 << (ADDR_W - 1)) - 1];

  assign accept = (state == IDLE) && bus.Req && !bus.Halt;

  // With LAT=1 the request reaches DONE on its acceptance edge, so the
  // access must use the live inputs; otherwise the captured copy is used.
  assign eff_wr   = (state == IDLE) ? bus.Wr     : cap_wr;
  assign eff_addr = (state == IDLE) ? bus.Addr   : cap_addr;
  assign eff_data = (state == IDLE) ? bus.DataIn : cap_data;

  // Next-state and latency counter.
  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LAT == 1) begin
            nxt = DONE;
          end else begin
            nxt     = BUSY;
            cnt_nxt = CNT_INIT;
          end
        end
      end
      BUSY: begin
        if (cnt == '0) nxt = DONE;
        else           cnt_nxt = cnt - 4'd1;
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign enter_done = (nxt == DONE) && (state != DONE);

  // State, captured request and registered response; response clears after the Done cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      cap_wr   <= 1'b0;
      cap_addr <= '0;
      cap_data <= '0;
      dout     <= '0;
      err      <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        cap_wr   <= bus.Wr;
        cap_addr <= bus.Addr;
        cap_data <= bus.DataIn;
      end
      if (enter_done) begin
        if (eff_addr[0]) begin
          dout <= '0;
          err  <= 1'b1;
        end else if (eff_wr) begin
          dout <= '0;
          err  <= 1'b0;
        end else begin
          dout <= mem[eff_addr[ADDR_W-1:1]];
          err  <= 1'b0;
        end
      end else if (state == DONE) begin
        dout <= '0;
        err  <= 1'b0;
      end
    end
  end

  // Array write on the edge entering DONE; contents survive reset.
  always_ff @(posedge clk) begin
    if (rst && enter_done && eff_wr && !eff_addr[0])
      mem[eff_addr[ADDR_W-1:1]] <= eff_data;
  end

  assign bus.Stall   = accept || (state == BUSY);
  assign bus.Done    = (state == DONE);
  assign bus.DataOut = dout;
  assign bus.Err     = err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (LAT=4, LAT=1, and
// ADDR_W=8 with LAT=15) sharing one clock and reset.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [2:0]  req  = '0;
  logic [2:0]  wr   = '0;
  logic [2:0]  halt = '0;
  logic [15:0] addr [3];
  logic [15:0] din  [3];
  logic [2:0]  stall, done, err;
  logic [15:0] dout [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_responder_if #(.ADDR_W(16)) if4 ();
  dmem_responder_if #(.ADDR_W(16)) if1 ();
  dmem_responder_if #(.ADDR_W(8))  if15 ();

  assign if4.Req = req[0];  assign if4.Wr = wr[0];  assign if4.Halt = halt[0];
  assign if4.Addr = addr[0]; assign if4.DataIn = din[0];
  assign stall[0] = if4.Stall; assign done[0] = if4.Done;
  assign err[0] = if4.Err;     assign dout[0] = if4.DataOut;

  assign if1.Req = req[1];  assign if1.Wr = wr[1];  assign if1.Halt = halt[1];
  assign if1.Addr = addr[1]; assign if1.DataIn = din[1];
  assign stall[1] = if1.Stall; assign done[1] = if1.Done;
  assign err[1] = if1.Err;     assign dout[1] = if1.DataOut;

  assign if15.Req = req[2];  assign if15.Wr = wr[2];  assign if15.Halt = halt[2];
  assign if15.Addr = addr[2][7:0]; assign if15.DataIn = din[2];
  assign stall[2] = if15.Stall; assign done[2] = if15.Done;
  assign err[2] = if15.Err;     assign dout[2] = if15.DataOut;

  dmem_responder #(.ADDR_W(16), .LAT(4))  u_dut4  (.clk(clk), .rst(rst), .bus(if4));
  dmem_responder #(.ADDR_W(16), .LAT(1))  u_dut1  (.clk(clk), .rst(rst), .bus(if1));
  dmem_responder #(.ADDR_W(8),  .LAT(15)) u_dut15 (.clk(clk), .rst(rst), .bus(if15));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One request on instance s; cycle 0 is the acceptance cycle.
  task automatic txn(input int s, input logic w, input logic [15:0] a, input logic [15:0] d,
                     input int halt_at, output logic [15:0] rd, output logic re,
                     output int lat, output logic [15:0] smask, output logic sdone);
    lat = -1; smask = '0; rd = '0; re = 1'b0; sdone = 1'b1;
    @(negedge clk);
    req[s] = 1'b1; wr[s] = w; addr[s] = a; din[s] = d;
    for (int i = 0; i < 40; i++) begin
      if (i == halt_at) halt[s] = 1'b1;
      #1;
      if (done[s]) begin
        lat = i; rd = dout[s]; re = err[s]; sdone = stall[s];
        break;
      end
      if (i < 16) smask[i] = stall[s];
      @(negedge clk);
    end
    req[s] = 1'b0;
    halt[s] = 1'b0;
  endtask

  task automatic rw(input string tag, input int s, input logic w, input logic [15:0] a,
                    input logic [15:0] d, input int halt_at, input int exp_lat,
                    input logic [15:0] exp_d, input logic exp_e);
    logic [15:0] rd, smask;
    logic        re, sdone;
    int          lat;
    txn(s, w, a, d, halt_at, rd, re, lat, smask, sdone);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_data"}, {16'h0, rd}, {16'h0, exp_d});
    chk({tag, "_err"}, {31'h0, re}, {31'h0, exp_e});
    chk({tag, "_stall"}, {16'h0, smask}, 32'((32'd1 << exp_lat) - 1));
    chk({tag, "_stall_done"}, {31'h0, sdone}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic seen_d, seen_s;
    int   k;
    for (int i = 0; i < 3; i++) begin addr[i] = '0; din[i] = '0; end

    // Reset state
    #3;
    chk("rst_done", {29'h0, done}, 32'h0);
    chk("rst_stall", {29'h0, stall}, 32'h0);
    chk("rst_err", {29'h0, err}, 32'h0);
    chk("rst_dout0", {16'h0, dout[0]}, 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // Reset mid-flight: write of 0xBEEF aborted two cycles after acceptance
    rw("pre_10", 0, 1'b1, 16'h0010, 16'h1234, -1, 4, 16'h0000, 1'b0);
    @(negedge clk);
    req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 16'h0010; din[0] = 16'hBEEF;
    #1 chk("abort_accept_stall", {31'h0, stall[0]}, 32'h1);
    seen_d = 1'b0;
    @(negedge clk); #1 seen_d |= done[0];
    @(negedge clk); rst = 1'b0; req[0] = 1'b0;
    #1 seen_d |= done[0];
    chk("abort_rst_stall", {31'h0, stall[0]}, 32'h0);
    @(negedge clk); #1 seen_d |= done[0];
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 6; i++) begin @(negedge clk); #1 seen_d |= done[0]; end
    chk("abort_no_done", {31'h0, seen_d}, 32'h0);
    rw("abort_rd", 0, 1'b0, 16'h0010, 16'h0000, -1, 4, 16'h1234, 1'b0);

    // Write then read, LAT=4
    rw("wr_20", 0, 1'b1, 16'h0020, 16'hA5A5, -1, 4, 16'h0000, 1'b0);
    rw("rd_20", 0, 1'b0, 16'h0020, 16'h0000, -1, 4, 16'hA5A5, 1'b0);

    // Unaligned accesses leave 0x0032 untouched
    rw("pre_32", 0, 1'b1, 16'h0032, 16'hCAFE, -1, 4, 16'h0000, 1'b0);
    rw("ua_rd31", 0, 1'b0, 16'h0031, 16'h0000, -1, 4, 16'h0000, 1'b1);
    rw("ua_wr33", 0, 1'b1, 16'h0033, 16'hFFFF, -1, 4, 16'h0000, 1'b1);
    rw("rd_32", 0, 1'b0, 16'h0032, 16'h0000, -1, 4, 16'hCAFE, 1'b0);

    // Halt in IDLE blocks acceptance
    @(negedge clk);
    halt[0] = 1'b1; req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 16'h0020;
    seen_d = 1'b0; seen_s = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1 seen_d |= done[0]; seen_s |= stall[0];
      @(negedge clk);
    end
    chk("halt_no_stall", {31'h0, seen_s}, 32'h0);
    chk("halt_no_done", {31'h0, seen_d}, 32'h0);
    req[0] = 1'b0; halt[0] = 1'b0;

    // Halt raised during BUSY does not delay an accepted read
    rw("halt_busy_rd", 0, 1'b0, 16'h0020, 16'h0000, 2, 4, 16'hA5A5, 1'b0);

    // Back-to-back reads, LAT=1, Req held high
    rw("pre_00", 1, 1'b1, 16'h0000, 16'h1111, -1, 1, 16'h0000, 1'b0);
    rw("pre_02", 1, 1'b1, 16'h0002, 16'h2222, -1, 1, 16'h0000, 1'b0);
    @(negedge clk);
    req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 16'h0000; k = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("b2b_done", {31'h0, done[1]}, {31'h0, (i % 2 == 1)});
      if (done[1]) begin
        chk("b2b_data", {16'h0, dout[1]}, (k % 2 == 1) ? 32'h2222 : 32'h1111);
        k++;
        addr[1] = (k % 2 == 1) ? 16'h0002 : 16'h0000;
      end
      @(negedge clk);
    end
    req[1] = 1'b0;
    chk("b2b_count", 32'(k), 32'd4);

    // ADDR_W=8, LAT=15: top word and counter boundary
    rw("wrap_wr", 2, 1'b1, 16'h00FE, 16'h7777, -1, 15, 16'h0000, 1'b0);
    rw("wrap_rd", 2, 1'b0, 16'h00FE, 16'h0000, -1, 15, 16'h7777, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
